// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the RV32I core.
// Holds the PC, picks sequential or execute-redirect next PC, and registers the fetch into decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        pcsrcE,
    input  logic [31:0] pctargetE,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrd,
    output logic [31:0] pcD,
    output logic [31:0] pcplus4D,
    output logic        validD
);

    logic [31:0] pcF;
    logic [31:0] pcplus4F;
    logic [31:0] pcnext;

    always_comb begin
        pcplus4F = pcF + 32'd4;
        pcnext   = pcsrcE ? {pctargetE[31:2], 2'b00} : pcplus4F;
    end

    // Redirect must win over stallF, so pcsrcE is tested before the hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pcF <= RESET_PC;
        end else if (pcsrcE || !stallF) begin
            pcF <= pcnext;
        end
    end

    assign imem_addr = pcF;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instrd   <= NOP_INSTR;
            pcD      <= '0;
            pcplus4D <= '0;
            validD   <= 1'b0;
        end else if (flushD) begin
            instrd   <= NOP_INSTR;
            pcD      <= '0;
            pcplus4D <= '0;
            validD   <= 1'b0;
        end else if (!stallD) begin
            instrd   <= imem_rdata;
            pcD      <= pcF;
            pcplus4D <= pcplus4F;
            validD   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes hand-computed expectations,
// a monitor pops and compares after each clock edge (or on an explicit async sample).
module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'h1234_5678;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST;
    logic        stallF, stallD, flushD, pcsrcE;
    logic [31:0] pctargetE;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] instrd, pcD, pcplus4D;
    logic        validD;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    event sample_ev;

    fetch_stage #(
        .RESET_PC (32'hBFC0_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .stallF    (stallF),
        .stallD    (stallD),
        .flushD    (flushD),
        .pcsrcE    (pcsrcE),
        .pctargetE (pctargetE),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .instrd    (instrd),
        .pcD       (pcD),
        .pcplus4D  (pcplus4D),
        .validD    (validD)
    );

    // Instruction memory: word content is its address xor a fixed key.
    assign imem_rdata = imem_addr ^ KEY;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    task automatic chk(input string tag, input string f, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=%h required=%h", tag, f, act, req);
        end
    endtask

    always begin
        @(posedge CLK);
        #2;
        ->sample_ev;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(sample_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.tag, "imem_addr", imem_addr, e.addr);
                chk(e.tag, "instrd", instrd, e.instr);
                chk(e.tag, "pcD", pcD, e.pc);
                chk(e.tag, "pcplus4D", pcplus4D, e.pc4);
                chk(e.tag, "validD", {31'd0, validD}, {31'd0, e.valid});
            end
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] p4, input logic v, input string tag);
        exp_t e;
        e.addr = a; e.instr = i; e.pc = p; e.pc4 = p4; e.valid = v; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic sf, input logic sd, input logic fd,
                         input logic ps, input logic [31:0] tgt);
        @(negedge CLK);
        RST = r; stallF = sf; stallD = sd; flushD = fd; pcsrcE = ps; pctargetE = tgt;
    endtask

    initial begin
        RST = 1'b1; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; pcsrcE = 1'b0; pctargetE = '0;
        push(32'hBFC00000, NOP, 0, 0, 1'b0, "reset0");
        drive(1, 0, 0, 0, 0, 0);
        push(32'hBFC00000, NOP, 0, 0, 1'b0, "reset1");

        drive(0, 0, 0, 0, 0, 0);
        push(32'hBFC00004, mem(32'hBFC00000), 32'hBFC00000, 32'hBFC00004, 1'b1, "run0");
        drive(0, 0, 0, 0, 0, 0);
        push(32'hBFC00008, mem(32'hBFC00004), 32'hBFC00004, 32'hBFC00008, 1'b1, "run1");

        drive(0, 1, 1, 0, 0, 0);
        push(32'hBFC00008, mem(32'hBFC00004), 32'hBFC00004, 32'hBFC00008, 1'b1, "stall0");
        drive(0, 1, 1, 0, 0, 0);
        push(32'hBFC00008, mem(32'hBFC00004), 32'hBFC00004, 32'hBFC00008, 1'b1, "stall1");
        drive(0, 0, 0, 0, 0, 0);
        push(32'hBFC0000C, mem(32'hBFC00008), 32'hBFC00008, 32'hBFC0000C, 1'b1, "unstall");

        drive(0, 0, 0, 1, 1, 32'hBFC00040);
        push(32'hBFC00040, NOP, 0, 0, 1'b0, "branch");
        drive(0, 0, 0, 0, 0, 0);
        push(32'hBFC00044, mem(32'hBFC00040), 32'hBFC00040, 32'hBFC00044, 1'b1, "target");

        // Redirect under stallF, flush together with stallD, unaligned target.
        drive(0, 1, 1, 1, 1, 32'hBFC00043);
        push(32'hBFC00040, NOP, 0, 0, 1'b0, "redir_stall");
        drive(0, 0, 0, 0, 0, 0);
        push(32'hBFC00044, mem(32'hBFC00040), 32'hBFC00040, 32'hBFC00044, 1'b1, "redir_tgt");

        // Redirect without flushD: decode still captures the wrong-path fetch.
        drive(0, 0, 0, 0, 1, 32'hFFFFFFFC);
        push(32'hFFFFFFFC, mem(32'hBFC00044), 32'hBFC00044, 32'hBFC00048, 1'b1, "wrap_redir");
        drive(0, 0, 0, 0, 0, 0);
        push(32'h00000000, mem(32'hFFFFFFFC), 32'hFFFFFFFC, 32'h00000000, 1'b1, "wrap");
        drive(0, 0, 0, 0, 0, 0);
        push(32'h00000004, mem(32'h00000000), 32'h00000000, 32'h00000004, 1'b1, "post_wrap");

        drive(0, 0, 1, 0, 0, 0);
        push(32'h00000008, mem(32'h00000000), 32'h00000000, 32'h00000004, 1'b1, "stallD_only");
        drive(0, 0, 0, 0, 0, 0);
        push(32'h0000000C, mem(32'h00000008), 32'h00000008, 32'h0000000C, 1'b1, "lost_fetch");

        drive(0, 1, 1, 0, 0, 0);
        push(32'h0000000C, mem(32'h00000008), 32'h00000008, 32'h0000000C, 1'b1, "pre_async");

        // Reset asserted mid-cycle during a stall, sampled before any clock edge.
        drive(1, 1, 1, 0, 0, 0);
        push(32'hBFC00000, NOP, 0, 0, 1'b0, "async_rst");
        #1;
        ->sample_ev;
        #1;
        push(32'hBFC00000, NOP, 0, 0, 1'b0, "rst_hold");
        drive(0, 0, 0, 0, 0, 0);
        push(32'hBFC00004, mem(32'hBFC00000), 32'hBFC00000, 32'hBFC00004, 1'b1, "restart");

        repeat (3) @(posedge CLK);
        #4;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined RV32I core. It sits directly upstream of the decode stage and supplies its `instrd`. It holds the program counter, selects the next PC (sequential or redirect from execute), and drives the instruction-memory address. It then registers the fetched instruction, PC and PC+4 into the decode stage under hazard-unit stall/flush control.

## Interface

**Parameters**
- `RESET_PC`, default `32'hBFC0_0000`: PC value loaded on reset.
- `NOP_INSTR`, default `32'h0000_0013`: bubble instruction (`addi x0,x0,0`) placed in decode on flush/reset.

**Ports**
- `CLK`  in  1  core clock; all state updates on rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `stallF`  in  1  hold PC (hazard unit).
- `stallD`  in  1  hold IF/ID register (hazard unit).
- `flushD`  in  1  replace IF/ID contents with bubble.
- `pcsrcE`  in  1  taken branch/jump/jalr resolved in execute.
- `pctargetE`  in  32  redirect target from execute.
- `imem_addr`  out  32  instruction memory address (= current `pcF`).
- `imem_rdata`  in  32  instruction word; combinational read of `imem_addr`, same cycle.
- `instrd`  out  32  registered instruction to decode.
- `pcD`  out  32  registered PC of `instrd`.
- `pcplus4D`  out  32  registered `pcD + 4`.
- `validD`  out  1  `instrd` is a real fetched instruction, not a bubble.

## Operation

- **Internal state:** `pcF` (32-bit) and the IF/ID register (`instrd`, `pcD`, `pcplus4D`, `validD`).
- **Sequential PC:** `pcplus4F = pcF + 32'd4`, modulo 2^32. `32'hFFFF_FFFC` wraps to `0`.
- **Next PC:** `pcnext = pcsrcE ? {pctargetE[31:2],2'b00} : pcplus4F`. The low two target bits are always cleared; no misalignment trap.
- **PC register priority:**
  1. `RST` loads `RESET_PC`.
  2. `pcsrcE` loads the redirect target, even when `stallF=1`. Redirect wins over stall.
  3. `stallF` holds `pcF`.
  4. Otherwise `pcF` loads `pcplus4F`.
- **`imem_addr`:** always equals `pcF`, with no added latency.
- **IF/ID register priority:**
  1. `RST` forces the bubble state.
  2. `flushD` loads `instrd=NOP_INSTR`, `pcD=0`, `pcplus4D=0`, `validD=0`. Flush wins over stall.
  3. `stallD` holds all four fields.
  4. Otherwise it loads `instrd=imem_rdata`, `pcD=pcF`, `pcplus4D=pcplus4F`, `validD=1`.
- **Redirect flushing is external:** the hazard unit asserts `flushD` together with `pcsrcE`. This block does not self-flush on `pcsrcE`.
- **No FSM beyond the two registers:** the stage is effectively in one of two states, "running" (`validD=1`) or "bubble" (`validD=0`).

## Timing

- **Reset values** (immediately on `RST` assertion, asynchronously):
  - `pcF`/`imem_addr = RESET_PC`
  - `instrd = NOP_INSTR`
  - `pcD = 0`, `pcplus4D = 0`, `validD = 0`
- **Reset release:** state holds while `RST=1`.
  - First rising edge after deassertion: the instruction at `RESET_PC` is captured into decode and `pcF` advances to `RESET_PC+4`.
- **Latency:** one cycle from `imem_addr=X` to `pcD=X`/`instrd=mem[X]` in decode.
- **Redirect:** with `pcsrcE=1` in cycle n, `imem_addr=target` in cycle n+1, and the target instruction reaches decode in cycle n+2. The wrong-path instruction fetched in cycle n is removed by the `flushD` asserted in cycle n.
- **Stall:** `stallF=stallD=1` for k cycles holds `imem_addr` and all decode outputs constant for k cycles. Fetch resumes on the first edge with both low.
- **Simultaneous events:**
  - `stallD=1` with `stallF=0` is legal. PC advances and the decode register holds, so that fetch is lost; the hazard unit never does this.
  - `flushD` and `stallD` together: flush.
  - `pcsrcE` and `stallF` together: redirect.
- **Reset mid-stream:** `RST` asserted in any cycle discards all in-flight state and restarts from `RESET_PC`.

## Test plan

- **Reset, then free-run:** assert `RST`, release, memory returns `imem_rdata = addr ^ 32'h1234_5678`.
  - Required: `imem_addr` steps `BFC00000, BFC00004, …`.
  - Required: one cycle later `pcD = BFC00000`, `instrd = BFC00000^12345678`, `pcplus4D = BFC00004`, `validD=1`.
- **Load-use stall:** `stallF=stallD=1` for 2 cycles while `pcF = BFC00008`.
  - Required: `imem_addr` stays `BFC00008` and `pcD` stays `BFC00004` for both cycles.
  - Required: `pcD = BFC00008` on the cycle after release.
- **Taken branch:** `pcsrcE=1`, `pctargetE=BFC00040`, `flushD=1` for one cycle.
  - Required: next cycle `imem_addr = BFC00040`, `instrd = 00000013`, `validD=0`.
  - Required: following cycle `pcD = BFC00040`, `validD=1`.
- **Redirect during stall with unaligned target:** `pcsrcE=1`, `stallF=1`, `pctargetE=BFC00043`.
  - Required: `imem_addr = BFC00040`.
- **Wrap:** force `pcF = FFFFFFFC` via redirect.
  - Required: next `imem_addr = 00000000` and `pcplus4D = 00000000`.
- **Asynchronous reset mid-run:** assert `RST` between clock edges during a stall.
  - Required: `imem_addr = BFC00000` and `validD = 0` immediately, without waiting for `CLK`.
